fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage. Issues PC-addressed reads to the
//             instruction memory, captures returned words into the IF/ID
//             register, absorbs one word in a skid buffer while decode is
//             stalled, and handles redirects, including redirects that arrive
//             while a memory request is still outstanding.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  // pipeline control
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  // IF/ID register
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [5:0]  o_if_op,
  output logic [31:0] o_if_pc4,
  output logic [31:0] o_pc
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  // Word-aligned view of the reset vector; the low bits are never used.
  localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic [31:0] r_skid;
  logic [31:0] r_skid_pc4;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc4;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;

  // Sequential PC increment wraps naturally at 2^32; redirect targets are
  // forced onto a word boundary.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

  // A request is outstanding in FETCH and DRAIN. In DRAIN the PC is left at
  // the old address so the address stays stable until memory completes.
  assign o_imem_req  = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_if_valid  = r_if_valid;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc4    = r_if_pc4;
  assign o_if_op     = r_if_instr[31:26];

  // Fetch FSM, PC, skid buffer and IF/ID register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= C_RESET_PC;
      r_pending_pc <= 32'd0;
      r_skid       <= 32'd0;
      r_skid_pc4   <= 32'd0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'd0;
      r_if_pc4     <= 32'd0;
    end else begin
      // Without a load this cycle the IF/ID entry is either flushed by a
      // redirect, consumed by decode, or held under stall. Loads below
      // override this.
      if (i_redirect || !i_stall) begin
        r_if_valid <= 1'b0;
      end

      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (i_imem_ready) begin
            if (i_redirect) begin
              // Returned word belongs to the wrong path: drop it.
              r_pc <= w_redirect_pc;
            end else if (i_stall && r_if_valid) begin
              // Decode is blocked; park the word and stop requesting.
              r_skid     <= i_imem_rdata;
              r_skid_pc4 <= w_pc_plus4;
              r_pc       <= w_pc_plus4;
              r_state    <= S_FULL;
            end else begin
              r_if_instr <= i_imem_rdata;
              r_if_pc4   <= w_pc_plus4;
              r_if_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
            end
          end else if (i_redirect) begin
            // Request still in flight: remember the target and let the
            // old request finish before switching address.
            r_pending_pc <= w_redirect_pc;
            r_state      <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (i_imem_ready) begin
            r_pc    <= i_redirect ? w_redirect_pc : r_pending_pc;
            r_state <= S_FETCH;
          end else if (i_redirect) begin
            r_pending_pc <= w_redirect_pc;
          end
        end

        S_FULL: begin
          if (i_redirect) begin
            r_pc    <= w_redirect_pc;
            r_state <= S_FETCH;
          end else if (!i_stall) begin
            r_if_instr <= r_skid;
            r_if_pc4   <= r_skid_pc4;
            r_if_valid <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed testbench for fetch_unit with a scoreboard of
//             expected IF/ID contents and a separate consumer-side monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  wire  [31:0] i_imem_rdata;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [5:0]  o_if_op;
  logic [31:0] o_if_pc4;
  logic [31:0] o_pc;

  int n_cmp = 0;
  int n_err = 0;

  // Fetch addresses whose words must reach decode, in order.
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rdata  (i_imem_rdata),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_if_valid    (o_if_valid),
    .o_if_instr    (o_if_instr),
    .o_if_op       (o_if_op),
    .o_if_pc4      (o_if_pc4),
    .o_pc          (o_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address-dependent word with varying opcode field.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Data is garbage unless memory is ready, so any stray capture shows up.
  assign i_imem_rdata = i_imem_ready ? mem(o_imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: decode consumes the IF/ID entry when valid, not stalled and not
  // flushed; compare it with the oldest expected fetch.
  always @(negedge clk) begin
    if (rst_n && o_if_valid && !i_stall && !i_redirect) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_instr: got %h expected none", o_if_instr);
      end else begin
        logic [31:0] a;
        logic [31:0] w;
        a = exp_q.pop_front();
        w = mem(a);
        chk("if_instr", o_if_instr, w);
        chk("if_pc4", o_if_pc4, a + 32'd4);
        chk("if_op", {26'd0, o_if_op}, {26'd0, w[31:26]});
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    i_imem_ready  = 1'b1;
    i_stall       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;

    // Reset state
    #3;
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_if_valid}, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_addr", o_imem_addr, 32'd0);
    chk("rst_instr", o_if_instr, 32'd0);
    chk("rst_pc4", o_if_pc4, 32'd0);
    chk("rst_op", {26'd0, o_if_op}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Streaming fetch after reset: one BOOT cycle, then 0,4,8,...
    chk("boot_req", {31'd0, o_imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, o_imem_req}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stream_addr", o_imem_addr, 32'(4 * i));
      exp_q.push_back(32'(4 * i));
      step();
    end
    i_imem_ready = 1'b0;
    step();

    // Stall with a word returning: goes to skid, then drains after unstall
    i_imem_ready = 1'b1;
    exp_q.push_back(32'd20);
    step();
    i_stall = 1'b1;
    exp_q.push_back(32'd24);
    step();
    i_imem_ready = 1'b0;
    chk("full_req", {31'd0, o_imem_req}, 32'd0);
    chk("full_hold_instr", o_if_instr, mem(32'd20));
    chk("full_hold_valid", {31'd0, o_if_valid}, 32'd1);
    step();
    chk("full_hold_instr2", o_if_instr, mem(32'd20));
    i_stall = 1'b0;
    step();
    chk("skid_instr", o_if_instr, mem(32'd24));
    chk("after_full_req", {31'd0, o_imem_req}, 32'd1);
    chk("after_full_addr", o_imem_addr, 32'd28);
    step();

    // Redirect with ready (target low bits masked), then redirect while waiting
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h13;
    i_imem_ready  = 1'b1;
    step();
    chk("redir_addr_0x10", o_imem_addr, 32'h10);
    chk("redir_valid", {31'd0, o_if_valid}, 32'd0);
    i_redirect   = 1'b0;
    i_imem_ready = 1'b0;
    step();
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h40;
    step();
    i_redirect = 1'b0;
    chk("drain_addr", o_imem_addr, 32'h10);
    chk("drain_req", {31'd0, o_imem_req}, 32'd1);
    chk("drain_valid", {31'd0, o_if_valid}, 32'd0);
    step();
    chk("drain_addr2", o_imem_addr, 32'h10);
    i_imem_ready = 1'b1;
    step();
    chk("after_drain_addr", o_imem_addr, 32'h40);
    chk("after_drain_valid", {31'd0, o_if_valid}, 32'd0);

    // Redirect coinciding with ready, unaligned target
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h83;
    step();
    chk("redir_ready_addr", o_imem_addr, 32'h80);
    chk("redir_ready_valid", {31'd0, o_if_valid}, 32'd0);

    // Wrap at top of address space
    i_redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
    i_redirect = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    i_imem_ready = 1'b0;
    chk("wrap_next_addr", o_imem_addr, 32'd0);
    chk("wrap_pc4", o_if_pc4, 32'd0);
    step();

    // Redirect takes priority over stall while FULL
    i_imem_ready = 1'b1;
    step();
    i_stall = 1'b1;
    step();
    i_imem_ready = 1'b0;
    chk("full2_req", {31'd0, o_imem_req}, 32'd0);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h100;
    step();
    i_redirect = 1'b0;
    i_stall    = 1'b0;
    chk("full_redir_valid", {31'd0, o_if_valid}, 32'd0);
    chk("full_redir_addr", o_imem_addr, 32'h100);
    chk("full_redir_req", {31'd0, o_imem_req}, 32'd1);

    // Asynchronous reset while draining
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    step();
    i_redirect = 1'b0;
    chk("pre_rst_req", {31'd0, o_imem_req}, 32'd1);
    chk("pre_rst_addr", o_imem_addr, 32'h100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, o_if_valid}, 32'd0);
    chk("async_rst_pc", o_pc, 32'd0);
    chk("async_rst_addr", o_imem_addr, 32'd0);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
